// File: rtl/sap_pkg.sv
// Shared SAP encodings: opcodes, bus source selects, sequencer states and the control word.
package sap_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned BUS_W = 3;
  localparam int unsigned TST_W = 3;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_STA = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'h4;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [BUS_W-1:0] BUS_NONE = 3'd0;
  localparam logic [BUS_W-1:0] BUS_PC   = 3'd1;
  localparam logic [BUS_W-1:0] BUS_RAM  = 3'd2;
  localparam logic [BUS_W-1:0] BUS_IR   = 3'd3;
  localparam logic [BUS_W-1:0] BUS_A    = 3'd4;
  localparam logic [BUS_W-1:0] BUS_ALU  = 3'd5;

  // T-states share their numeric value with the tstate debug output.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic [BUS_W-1:0] bus_sel;
    logic             pc_inc;
    logic             pc_load;
    logic             mar_in;
    logic             ram_in;
    logic             ram_out;
    logic             ir_in;
    logic             a_in;
    logic             b_in;
    logic             alu_sub;
    logic             out_in;
  } ctrl_t;

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational (state, opcode) -> control word decoder for the SAP sequencer.
// Ports: state/opcode in; ctrl (control word), tstate (debug T-number), halted out.
module sap_ctrl_decode
  import sap_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  state_t                state,
  input  logic [OPC_W-1:0]      opcode,
  output ctrl_t                 ctrl,
  output logic [TST_W-1:0]      tstate,
  output logic                  halted
);

  // Control word per T-state; fetch is opcode-independent, execute keys off opcode.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_T1: begin
        ctrl.bus_sel = BUS_PC;
        ctrl.mar_in  = 1'b1;
      end
      ST_T2: begin
        ctrl.ram_out = 1'b1;
        ctrl.pc_inc  = 1'b1;
      end
      ST_T3: begin
        ctrl.bus_sel = BUS_RAM;
        ctrl.ir_in   = 1'b1;
      end
      ST_T4: begin
        case (opcode)
          OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_STA): begin
            ctrl.bus_sel = BUS_IR;
            ctrl.mar_in  = 1'b1;
          end
          OPC_W'(OP_JMP): begin
            ctrl.bus_sel = BUS_IR;
            ctrl.pc_load = 1'b1;
          end
          OPC_W'(OP_OUT): begin
            ctrl.bus_sel = BUS_A;
            ctrl.out_in  = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      ST_T5: begin
        case (opcode)
          OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB): ctrl.ram_out = 1'b1;
          OPC_W'(OP_STA): begin
            ctrl.bus_sel = BUS_A;
            ctrl.ram_in  = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      ST_T6: begin
        case (opcode)
          OPC_W'(OP_LDA): begin
            ctrl.bus_sel = BUS_RAM;
            ctrl.a_in    = 1'b1;
          end
          OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
            ctrl.bus_sel = BUS_RAM;
            ctrl.b_in    = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      ST_T7: begin
        if (opcode == OPC_W'(OP_ADD) || opcode == OPC_W'(OP_SUB)) begin
          ctrl.bus_sel = BUS_ALU;
          ctrl.a_in    = 1'b1;
          ctrl.alu_sub = (opcode == OPC_W'(OP_SUB));
        end
      end
      default: ctrl = '0;
    endcase
  end

  // Debug T-number; IDLE, HALT and unreachable encodings all read as 0.
  always_comb begin
    tstate = '0;
    halted = 1'b0;
    case (state)
      ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: tstate = TST_W'(state);
      ST_HALT: halted = 1'b1;
      default: tstate = '0;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP controller/sequencer: fetch T1-T3, variable-length execute T4-T7, IDLE and HALT.
// Ports: clock, reset (async, active-high), run, opcode (IR[7:4]) in;
//        bus_sel, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, a_in, b_in, alu_sub,
//        out_in, halted, tstate out (combinational decode of the state register).
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned OPC_W        = 4,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  output logic [2:0]       bus_sel,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_in,
  output logic             ram_in,
  output logic             ram_out,
  output logic             ir_in,
  output logic             a_in,
  output logic             b_in,
  output logic             alu_sub,
  output logic             out_in,
  output logic             halted,
  output logic [2:0]       tstate
);

  state_t state;
  state_t state_nxt;
  state_t end_nxt;
  ctrl_t  ctrl;

  // State register; reset lands in IDLE so all decoded outputs drop at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Where an instruction goes on its last T-state: straight into the next fetch or IDLE.
  assign end_nxt = run ? ST_T1 : ST_IDLE;

  // Next-state: each opcode ends at its own last T-state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = run ? ST_T1 : ST_IDLE;
      ST_T1:   state_nxt = ST_T2;
      ST_T2:   state_nxt = ST_T3;
      ST_T3:   state_nxt = ST_T4;
      ST_T4: begin
        case (opcode)
          OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_STA): state_nxt = ST_T5;
          OPC_W'(OP_HLT):                 state_nxt = ST_HALT;
          OPC_W'(OP_JMP), OPC_W'(OP_OUT): state_nxt = end_nxt;
          default: state_nxt = ILLEGAL_HALT ? ST_HALT : end_nxt;
        endcase
      end
      ST_T5:   state_nxt = (opcode == OPC_W'(OP_STA)) ? end_nxt : ST_T6;
      ST_T6:   state_nxt = (opcode == OPC_W'(OP_LDA)) ? end_nxt : ST_T7;
      ST_T7:   state_nxt = end_nxt;
      ST_HALT: state_nxt = ST_HALT;
      // Unreachable encodings behave as IDLE.
      default: state_nxt = run ? ST_T1 : ST_IDLE;
    endcase
  end

  sap_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .state  (state),
    .opcode (opcode),
    .ctrl   (ctrl),
    .tstate (tstate),
    .halted (halted)
  );

  assign bus_sel = ctrl.bus_sel;
  assign pc_inc  = ctrl.pc_inc;
  assign pc_load = ctrl.pc_load;
  assign mar_in  = ctrl.mar_in;
  assign ram_in  = ctrl.ram_in;
  assign ram_out = ctrl.ram_out;
  assign ir_in   = ctrl.ir_in;
  assign a_in    = ctrl.a_in;
  assign b_in    = ctrl.b_in;
  assign alu_sub = ctrl.alu_sub;
  assign out_in  = ctrl.out_in;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: directed instruction runs, mid-clock reset,
// HLT, run drop, randomized run/opcode streams against a microprogram-table reference model,
// plus a second instance built with ILLEGAL_HALT=1.
module tb_sap_control_sequencer;

  // Control word layout: [12:10] bus_sel, then pc_inc pc_load mar_in ram_in ram_out
  // ir_in a_in b_in alu_sub out_in.
  localparam logic [9:0] PI = 10'h200, PL = 10'h100, MI = 10'h080, RI = 10'h040, RO = 10'h020;
  localparam logic [9:0] II = 10'h010, AI = 10'h008, BI = 10'h004, SU = 10'h002, OI = 10'h001;
  localparam logic [3:0] LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, STA = 4'h3, JMP = 4'h4;
  localparam logic [3:0] OUTI = 4'hE, HLT = 4'hF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [2:0] bus_sel, tstate;
  logic       pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, a_in, b_in, alu_sub, out_in;
  logic       halted;

  logic       reset_ih = 1'b1;
  logic       run_ih = 1'b0;
  logic [3:0] opcode_ih = 4'h0;
  logic [2:0] bus_sel_ih, tstate_ih;
  logic       pc_inc_ih, pc_load_ih, mar_in_ih, ram_in_ih, ram_out_ih, ir_in_ih, a_in_ih;
  logic       b_in_ih, alu_sub_ih, out_in_ih, halted_ih;

  int compared = 0;
  int mismatched = 0;
  int m_mode = 0;  // 0 idle, 1 executing, 2 halted
  int m_t = 0;

  always #5 clock = ~clock;

  sap_control_sequencer #(.OPC_W(4), .ILLEGAL_HALT(1'b0)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .bus_sel(bus_sel), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
    .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .a_in(a_in), .b_in(b_in),
    .alu_sub(alu_sub), .out_in(out_in), .halted(halted), .tstate(tstate)
  );

  sap_control_sequencer #(.OPC_W(4), .ILLEGAL_HALT(1'b1)) dut_ih (
    .clock(clock), .reset(reset_ih), .run(run_ih), .opcode(opcode_ih),
    .bus_sel(bus_sel_ih), .pc_inc(pc_inc_ih), .pc_load(pc_load_ih), .mar_in(mar_in_ih),
    .ram_in(ram_in_ih), .ram_out(ram_out_ih), .ir_in(ir_in_ih), .a_in(a_in_ih),
    .b_in(b_in_ih), .alu_sub(alu_sub_ih), .out_in(out_in_ih), .halted(halted_ih),
    .tstate(tstate_ih)
  );

  logic [12:0] dut_w;
  assign dut_w = {bus_sel, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, a_in, b_in,
                  alu_sub, out_in};

  function automatic logic [12:0] cw(input int bus, input logic [9:0] flags);
    return {3'(bus), flags};
  endfunction

  // Microprogram listing: word for each T-state, instruction length, halts-after flag.
  function automatic int prog(input logic [3:0] op, input bit ih,
                              output logic [7:0][12:0] p, output bit hl);
    p = '0;
    hl = 1'b0;
    p[1] = cw(1, MI);
    p[2] = cw(0, RO | PI);
    p[3] = cw(2, II);
    case (op)
      LDA: begin p[4] = cw(3, MI); p[5] = cw(0, RO); p[6] = cw(2, AI); return 6; end
      ADD, SUB: begin
        p[4] = cw(3, MI); p[5] = cw(0, RO); p[6] = cw(2, BI);
        p[7] = cw(5, (op == SUB) ? (AI | SU) : AI);
        return 7;
      end
      STA:  begin p[4] = cw(3, MI); p[5] = cw(4, RI); return 5; end
      JMP:  begin p[4] = cw(3, PL); return 4; end
      OUTI: begin p[4] = cw(4, OI); return 4; end
      HLT:  begin hl = 1'b1; return 4; end
      default: begin hl = ih; return 4; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0][12:0] p;
    bit hl;
    int len;
    logic [12:0] expw;
    int nb;
    len = prog(opcode, 1'b0, p, hl);
    expw = (m_mode == 1) ? p[m_t] : 13'h0;
    chk({tag, "_ctrl"}, dut_w, expw);
    chk({tag, "_tstate"}, 13'(tstate), (m_mode == 1) ? 13'(m_t) : 13'h0);
    chk({tag, "_halted"}, 13'(halted), 13'(m_mode == 2));
    nb = $countones({mar_in, ram_in, ir_in, a_in, b_in, out_in, pc_load});
    chk({tag, "_bus_consumers"}, 13'((bus_sel == 3'd0 && nb != 0) || nb > 1), 13'h0);
    chk({tag, "_pc_both"}, 13'(pc_inc & pc_load), 13'h0);
  endtask

  task automatic advance(input logic r);
    logic [7:0][12:0] p;
    bit hl;
    int len;
    len = prog(opcode, 1'b0, p, hl);
    if (m_mode == 0) begin
      if (r) begin m_mode = 1; m_t = 1; end
    end else if (m_mode == 1) begin
      if (m_t < len) m_t++;
      else if (hl) begin m_mode = 2; m_t = 0; end
      else if (r) m_t = 1;
      else begin m_mode = 0; m_t = 0; end
    end
  endtask

  // One clock: drive at negedge (opcode held from T4 to instruction end), check, advance.
  task automatic step(input logic r, input logic [3:0] op, input string tag);
    @(negedge clock);
    run = r;
    if (!(m_mode == 1 && m_t >= 4)) opcode = op;
    #1 check_all(tag);
    @(posedge clock);
    advance(r);
  endtask

  task automatic do_reset(input string tag);
    run = 1'b0;
    reset = 1'b1;
    m_mode = 0;
    m_t = 0;
    #1 check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] rand_op();
    int x;
    logic [3:0] legal [6];
    legal = '{LDA, ADD, SUB, STA, JMP, OUTI};
    x = int'($urandom % 100);
    if (x < 3) return HLT;
    if (x < 12) return 4'(5 + ($urandom % 9));
    return legal[$urandom % 6];
  endfunction

  initial begin
    int guard;
    do_reset("reset");

    repeat (14) step(1'b1, LDA, "lda");
    repeat (16) step(1'b1, SUB, "sub");
    repeat (16) step(1'b1, ADD, "add");
    repeat (12) step(1'b1, STA, "sta");
    repeat (10) step(1'b1, JMP, "jmp");
    repeat (10) step(1'b1, OUTI, "out");
    repeat (10) step(1'b1, 4'h7, "nop");
    repeat (6)  step(1'b1, HLT, "hlt");
    for (int i = 0; i < 24; i++) step(1'($urandom % 2), HLT, "halt_hold");
    do_reset("reset_from_halt");

    // Reset between clock edges while STA is in T5.
    guard = 0;
    while (!(m_mode == 1 && m_t == 5) && guard < 20) begin
      step(1'b1, STA, "sta_lead");
      guard++;
    end
    chk("sta_t5_reached", 13'(guard < 20), 13'h1);
    @(negedge clock);
    #1 check_all("sta_t5");
    #2 do_reset("async_reset");

    // run drops during ADD T5: T6, T7 complete, then IDLE.
    guard = 0;
    while (!(m_mode == 1 && m_t == 5) && guard < 20) begin
      step(1'b1, ADD, "add_lead");
      guard++;
    end
    chk("add_t5_reached", 13'(guard < 20), 13'h1);
    repeat (5) step(1'b0, ADD, "run_drop");
    chk("run_drop_idle", 13'(m_mode), 13'h0);

    for (int i = 0; i < 600; i++) begin
      if (m_mode == 2 && ($urandom % 6) == 0) do_reset("rand_reset");
      step(1'(($urandom % 5) != 0), rand_op(), "rand");
    end

    // Undefined opcode halts in the ILLEGAL_HALT=1 build.
    @(negedge clock);
    reset_ih = 1'b0;
    run_ih = 1'b1;
    opcode_ih = 4'h7;
    repeat (4) @(posedge clock);
    #1 chk("ih_t4", 13'(tstate_ih), 13'h4);
    @(posedge clock);
    #1 chk("ih_halted", 13'(halted_ih), 13'h1);
    chk("ih_tstate", 13'(tstate_ih), 13'h0);
    repeat (3) @(posedge clock);
    #1 chk("ih_halt_hold", 13'({halted_ih, bus_sel_ih, mar_in_ih, pc_inc_ih}), 13'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
